// File: rtl/scroll_ctrl.sv
// Scroll offset controller: debounced push-buttons pick a direction and the
// offsets step once every FRAMES_PER_STEP vblanks. Define SCROLL_WRAP_EN to wrap offsets instead of saturating.
module scroll_ctrl #(
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int STEP            = 5,
  parameter int FRAMES_PER_STEP = 1,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       BTNC,
  input  logic       VBLANK_START,
  output logic [9:0] H_SHIFT,
  output logic [9:0] V_SHIFT,
  output logic [2:0] DIR,
  output logic       SHIFT_VALID
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FC_W = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0]     STEP11  = 11'(STEP);

  // In the wrap build the bound is the modulus; otherwise it is the highest reachable STEP multiple.
`ifdef SCROLL_WRAP_EN
  localparam logic [10:0] H_BOUND = 11'(H_RES);
  localparam logic [10:0] V_BOUND = 11'(V_RES);
`else
  localparam logic [10:0] H_BOUND = 11'(((H_RES - STEP) / STEP) * STEP);
  localparam logic [10:0] V_BOUND = 11'(((V_RES - STEP) / STEP) * STEP);
`endif

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } state_e;

  // Button bit order: 4=C, 3=U, 2=D, 1=R, 0=L
  logic [4:0]      btn_raw;
  logic [4:0]      sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q [5];
  logic [DB_W-1:0] db_cnt_d [5];
  logic [4:0]      press;
  logic            dir_event;
  dir_e            new_dir;

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  logic [FC_W-1:0] frame_q, frame_d;
  logic [9:0]      h_q, h_d, v_q, v_d;

  assign btn_raw = {BTNC, BTNU, BTND, BTNR, BTNL};

  function automatic logic [9:0] step_off(input logic [9:0] cur, input logic up,
                                          input logic [10:0] bound);
    logic [10:0] ext, nxt;
    ext = {1'b0, cur};
`ifdef SCROLL_WRAP_EN
    if (up) nxt = (ext + STEP11 >= bound) ? ext + STEP11 - bound : ext + STEP11;
    else    nxt = (ext < STEP11) ? ext + bound - STEP11 : ext - STEP11;
`else
    if (up) nxt = (ext + STEP11 > bound) ? bound : ext + STEP11;
    else    nxt = (ext < STEP11) ? 11'd0 : ext - STEP11;
`endif
    return 10'(nxt);
  endfunction

  // A press fires once, on the DEBOUNCE_CYCLES-th consecutive high sample; the counter then parks.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      press[i]    = sync2_q[i] && (db_cnt_q[i] == DB_LAST);
      if (!sync2_q[i])              db_cnt_d[i] = '0;
      else if (db_cnt_q[i] != DB_MAX) db_cnt_d[i] = db_cnt_q[i] + 1'b1;
    end
    dir_event = |press;
    new_dir   = DIR_NONE;
    if (press[4])      new_dir = DIR_NONE;
    else if (press[3]) new_dir = DIR_UP;
    else if (press[2]) new_dir = DIR_DOWN;
    else if (press[1]) new_dir = DIR_RIGHT;
    else if (press[0]) new_dir = DIR_LEFT;
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    dir_d   = dir_q;
    h_d     = h_q;
    v_d     = v_q;
    if (dir_event) dir_d = new_dir;
    case (state_q)
      IDLE: begin
        if (dir_event && new_dir != DIR_NONE) begin
          state_d = WAIT;
          frame_d = '0;
        end
      end
      WAIT: begin
        // A direction change restarts the frame count and swallows a coincident vblank.
        if (dir_event) begin
          frame_d = '0;
          if (new_dir == DIR_NONE) state_d = IDLE;
        end else if (VBLANK_START) begin
          if (int'(frame_q) + 1 >= FRAMES_PER_STEP) begin
            state_d = APPLY;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      APPLY: begin
        case (dir_q)
          DIR_UP:    v_d = step_off(v_q, 1'b1, V_BOUND);
          DIR_DOWN:  v_d = step_off(v_q, 1'b0, V_BOUND);
          DIR_RIGHT: h_d = step_off(h_q, 1'b1, H_BOUND);
          DIR_LEFT:  h_d = step_off(h_q, 1'b0, H_BOUND);
          default:   ;
        endcase
        frame_d = '0;
        state_d = (dir_d != DIR_NONE) ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      state_q <= IDLE;
      dir_q   <= DIR_NONE;
      frame_q <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q <= state_d;
      dir_q   <= dir_d;
      frame_q <= frame_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // New offsets are visible during the APPLY cycle itself, so a reset there drops the update.
  assign H_SHIFT     = h_d;
  assign V_SHIFT     = v_d;
  assign DIR         = dir_q;
  assign SHIFT_VALID = (state_q == APPLY);

endmodule

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 Params SHALL be: H_RES 640 (horizontal wrap/limit); V_RES 480 (vertical wrap/limit); STEP 5 (pixels per update); FRAMES_PER_STEP 1 (vblanks per update, >=1); DEBOUNCE_CYCLES 250000 (stable CLK cycles per button edge).
REQ-002 CLK  input  1  single clock; all logic on posedge CLK.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 BTNU, BTND, BTNL, BTNR, BTNC  input  1 each  raw asynchronous push-buttons.
REQ-005 VBLANK_START  input  1  one-cycle pulse from the timing generator at the first pixel of line V_RES.
REQ-006 H_SHIFT  output  10  horizontal scroll offset, range 0..H_RES-1.
REQ-007 V_SHIFT  output  10  vertical scroll offset, range 0..V_RES-1.
REQ-008 DIR  output  3  latched direction: 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT.
REQ-009 SHIFT_VALID  output  1  one-cycle pulse in the cycle H_SHIFT/V_SHIFT change.

Function
REQ-010 Each button SHALL pass a 2-flop synchronizer, then a debouncer that reports a press only after DEBOUNCE_CYCLES consecutive high samples; one press = one-cycle event, no repeat while held.
REQ-011 Press events SHALL set DIR with priority BTNC(NONE) > BTNU > BTND > BTNR > BTNL when simultaneous.
REQ-012 FSM states SHALL be IDLE, WAIT, APPLY.
REQ-013 IDLE -> WAIT when DIR becomes non-NONE; frame counter cleared.
REQ-014 WAIT: each VBLANK_START increments frame counter; the pulse at which the count reaches FRAMES_PER_STEP SHALL move to APPLY and clear the counter.
REQ-015 APPLY lasts exactly one cycle: updates the offset, asserts SHIFT_VALID, then -> WAIT (DIR non-NONE) or IDLE (DIR NONE).
REQ-016 Updates: UP V_SHIFT+STEP; DOWN V_SHIFT-STEP; RIGHT H_SHIFT+STEP; LEFT H_SHIFT-STEP; only one axis per APPLY.
REQ-017 Offset arithmetic SHALL use 11-bit intermediates; the output never leaves 0..RES-1.
REQ-018 A direction-change event in WAIT SHALL clear the frame counter; a VBLANK_START in the same cycle as the event SHALL be ignored for counting.
REQ-019 BTNC in WAIT SHALL return to IDLE next cycle with no further update; offsets hold.
REQ-020 Latency: SHIFT_VALID and new offsets SHALL appear exactly 1 cycle after the qualifying VBLANK_START.
REQ-021 Offsets SHALL change only in APPLY; they hold otherwise.

Reset
REQ-022 RST_N low SHALL immediately force: H_SHIFT 0, V_SHIFT 0, DIR 0, SHIFT_VALID 0, state IDLE, frame and debounce counters 0, synchronizers 0.
REQ-023 Reset asserted mid-APPLY SHALL discard the pending update; deassertion resumes in IDLE.

Configuration
REQ-024 Macro SCROLL_WRAP_EN defined: offsets wrap modulo H_RES/V_RES (e.g. V_SHIFT 0 DOWN -> 475, H_SHIFT 635 RIGHT -> 0).
REQ-025 SCROLL_WRAP_EN undefined: offsets saturate at 0 and RES-STEP rounded down to a STEP multiple; at a limit APPLY still pulses SHIFT_VALID with the value unchanged.

Verification (DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=2 unless noted)
REQ-026 Reset, no buttons, 10 VBLANK_START -> H_SHIFT=V_SHIFT=0, DIR=0, SHIFT_VALID never high.
REQ-027 BTNU held 6 cycles, then 4 VBLANK_START -> DIR=1, two SHIFT_VALID pulses, each 1 cycle after vblanks 2 and 4; V_SHIFT 0->5->10.
REQ-028 Wrap build, FRAMES_PER_STEP=1, BTND then 1 VBLANK_START -> V_SHIFT=475; non-wrap build -> V_SHIFT=0 with SHIFT_VALID pulsed.
REQ-029 BTNR, 1 vblank, BTNL press coincident with 2nd vblank, 2 more vblanks -> no update at vblank 2; H_SHIFT=635 after 2nd later vblank (wrap build).
REQ-030 BTNU bouncing high 3 cycles / low 1 repeatedly -> DIR stays 0; BTNU+BTNL together stable -> DIR=1; BTNC -> DIR=0, state IDLE.
REQ-031 RST_N low in the APPLY cycle -> outputs 0 asynchronously, no SHIFT_VALID, offsets 0 after release.
